// File: rtl/lut_mask_loader.sv
// Streams WORD_W-bit configuration words into M-bit LUT masks and writes
// NUM_LUTS of them, one per strobe, to an external LUT mask store.
module lut_mask_loader #(
  parameter  int K        = 6,
  parameter  int NUM_LUTS = 16,
  parameter  int WORD_W   = 32,
  localparam int M        = 1 << K,
  localparam int AW       = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cfg_we,
  output logic [AW-1:0]     cfg_addr,
  output logic [M-1:0]      cfg_mask,
  output logic              busy,
  output logic              done
);

  localparam int W  = M / WORD_W;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [CW-1:0] WORD_LAST = CW'(W - 1);
  localparam logic [AW-1:0] LUT_LAST  = AW'(NUM_LUTS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   word_cnt;
  logic [AW-1:0]   lut_cnt;
  logic            xfer;
  logic            last_word;
  logic            restart;
  logic [M-1:0]    mask_full;

  assign xfer      = in_ready && in_valid;
  assign last_word = (word_cnt == WORD_LAST);
  assign restart   = ((state == IDLE) || (state == DONE)) && start;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // in_ready is decoded from state alone, so it never depends on in_valid.
  // NOTE: every output of this block is defaulted first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    cfg_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last_word) state_next = WRITE;
      end
      WRITE: begin
        cfg_we     = 1'b1;
        busy       = 1'b1;
        state_next = (lut_cnt == LUT_LAST) ? DONE : LOAD;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_cnt <= '0;
      lut_cnt  <= '0;
    end else if (restart) begin
      word_cnt <= '0;
      lut_cnt  <= '0;
    end else if (xfer) begin
      word_cnt <= last_word ? '0 : word_cnt + 1'b1;
    end else if ((state == WRITE) && (lut_cnt != LUT_LAST)) begin
      lut_cnt <= lut_cnt + 1'b1;
    end
  end

  // The first W-1 words of a mask wait here; the last word joins them
  // directly from in_data, so the earliest word ends up in the top bits.
  if (W > 1) begin : g_multi_word
    logic [M-WORD_W-1:0] shift_q;

    // NOTE: no reset here on purpose; all W-1 words are rewritten before any
    // mask is assembled, so stale contents after reset are never observed.
    always_ff @(posedge clock) begin
      if (xfer) shift_q <= (M - WORD_W)'({shift_q, in_data});
    end

    assign mask_full = {shift_q, in_data};
  end else begin : g_single_word
    assign mask_full = in_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cfg_mask <= '0;
      cfg_addr <= '0;
    end else if (xfer && last_word) begin
      cfg_mask <= mask_full;
      cfg_addr <= lut_cnt;
    end
  end

endmodule

// File: tb/tb_lut_mask_loader.sv
// Self-checking bench for lut_mask_loader: randomized word streams compared
// every cycle against a transaction-level model, plus literal spot checks.
module tb_lut_mask_loader;

  localparam int K        = 6;
  localparam int NUM_LUTS = 4;
  localparam int WORD_W   = 32;
  localparam int M        = 64;
  localparam int W        = 2;
  localparam int AW       = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [M-1:0]      cfg_mask;
  logic              busy;
  logic              done;

  lut_mask_loader #(.K(K), .NUM_LUTS(NUM_LUTS), .WORD_W(WORD_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_mask (cfg_mask),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int start_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Transaction-level model: counts accepted words in the current load and
  // places each one into its mask slot by position.
  typedef struct packed {
    bit          active;
    bit          fin;
    bit          wr;
    int          words;
    logic [M-1:0] pend;
    logic [M-1:0] mask;
    int          addr;
  } model_t;

  model_t mdl;

  function automatic model_t step(model_t c, logic s, logic v, logic [WORD_W-1:0] d);
    model_t n = c;
    int part;
    if (c.wr) begin
      n.wr = 1'b0;
      if (c.words == NUM_LUTS * W) begin
        n.active = 1'b0;
        n.fin    = 1'b1;
      end
    end else if (c.active) begin
      if (v) begin
        part = c.words % W;
        n.pend[(W - 1 - part) * WORD_W +: WORD_W] = d;
        n.words = c.words + 1;
        if (part == W - 1) begin
          n.mask = n.pend;
          n.addr = c.words / W;
          n.wr   = 1'b1;
        end
      end
    end else if (s) begin
      n.active = 1'b1;
      n.fin    = 1'b0;
      n.words  = 0;
    end
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) mdl <= '0;
    else       mdl <= step(mdl, start, in_valid, in_data);
  end

  typedef struct {
    int          cyc;
    int          addr;
    logic [63:0] mask;
  } wr_t;

  wr_t               wlog[$];
  logic [WORD_W-1:0] sent_q[$];
  logic [WORD_W-1:0] pend_q[$];

  always @(negedge clock) begin
    check("in_ready", 64'(in_ready), 64'(mdl.active && !mdl.wr));
    check("cfg_we",   64'(cfg_we),   64'(mdl.wr));
    check("busy",     64'(busy),     64'(mdl.active));
    check("done",     64'(done),     64'(mdl.fin));
    check("cfg_addr", 64'(cfg_addr), 64'(mdl.addr));
    check("cfg_mask", cfg_mask,      mdl.mask);
    if (cfg_we) wlog.push_back('{cyc: cyc, addr: int'(cfg_addr), mask: cfg_mask});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit rnd_valid, input bit poke_start);
    int sent  = 0;
    int guard = 0;
    logic [WORD_W-1:0] w;
    w = (pend_q.size() > 0) ? pend_q.pop_front() : WORD_W'($urandom);
    while (sent < n && guard < 2000) begin
      in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = w;
      start    = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
      if (in_valid && in_ready) begin
        sent++;
        sent_q.push_back(w);
        w = (pend_q.size() > 0) ? pend_q.pop_front() : WORD_W'($urandom);
      end
      tick();
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("feed_budget", 64'(sent), 64'(n));
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done && g < 50) begin
      tick();
      g++;
    end
    check("done_reached", 64'(done), 64'd1);
  endtask

  task automatic check_log(input string tag, input bit timing);
    check({tag, "_count"}, 64'(wlog.size()), 64'(NUM_LUTS));
    for (int i = 0; i < NUM_LUTS && i < wlog.size(); i++) begin
      check({tag, "_addr"}, 64'(wlog[i].addr), 64'(i));
      check({tag, "_mask"}, wlog[i].mask, {sent_q[2*i], sent_q[2*i+1]});
      if (timing)
        check({tag, "_spacing"},
              64'((i == 0) ? wlog[0].cyc - start_cyc : wlog[i].cyc - wlog[i-1].cyc),
              64'(W + 1));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    64'(cfg_we),   64'd0);
    check({tag, "_addr"},  64'(cfg_addr), 64'd0);
    check({tag, "_mask"},  cfg_mask,      64'd0);
    check({tag, "_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_busy"},  64'(busy),     64'd0);
    check({tag, "_done"},  64'(done),     64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) tick();
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Known first mask, then a continuous stream of 8 words.
    wlog.delete(); sent_q.delete();
    pend_q = '{32'hDEADBEEF, 32'h01234567};
    do_start();
    check("start_busy", 64'(busy), 64'd1);
    feed(8, 1'b0, 1'b0);
    wait_done();
    check("first_mask",    wlog.size() > 0 ? wlog[0].mask : 64'd0, 64'hDEADBEEF01234567);
    check("first_addr",    wlog.size() > 0 ? 64'(wlog[0].addr) : 64'hFF, 64'd0);
    check("first_latency", wlog.size() > 0 ? 64'(wlog[0].cyc - start_cyc) : 64'd0, 64'd3);
    check_log("stream", 1'b1);
    check("stream_busy", 64'(busy), 64'd0);
    in_valid = 1'b1;
    repeat (3) tick();
    check("done_held",  64'(done),     64'd1);
    check("done_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;

    // Restart from DONE, random in_valid.
    wlog.delete(); sent_q.delete();
    do_start();
    check("restart_done", 64'(done), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    feed(8, 1'b1, 1'b0);
    wait_done();
    check_log("rand", 1'b0);

    // Long stall mid-load, then random start pokes while loading.
    wlog.delete(); sent_q.delete();
    do_start();
    feed(1, 1'b0, 1'b0);
    repeat (20) tick();
    check("stall_writes", 64'(wlog.size()), 64'd0);
    check("stall_ready",  64'(in_ready),    64'd1);
    feed(7, 1'b1, 1'b1);
    wait_done();
    check_log("stall", 1'b0);

    // Reset after three words discards the partial load.
    wlog.delete(); sent_q.delete();
    do_start();
    feed(3, 1'b0, 1'b0);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    in_valid = 1'b1;
    tick();
    tick();
    @(negedge clock);
    reset = 1'b0;
    tick();
    tick();
    check("postreset_writes", 64'(wlog.size()), 64'd1);
    check("postreset_busy",   64'(busy),        64'd0);
    in_valid = 1'b0;
    wlog.delete(); sent_q.delete();
    do_start();
    feed(8, 1'b1, 1'b0);
    wait_done();
    check_log("after_reset", 1'b0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
